// File: rtl/max7219_frame_receiver_pkg.sv
// +-------------------------------------------------------------------------+
// | max7219_frame_receiver_pkg                                              |
// | Shared address map, word size and FSM encoding for the MAX7219 receiver |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

package max7219_frame_receiver_pkg;

  localparam int WORD_BITS = 16;
  localparam int CNT_W     = 5;

  localparam logic [3:0] ADDR_NOOP    = 4'h0;
  localparam logic [3:0] ADDR_DIG1    = 4'h1;
  localparam logic [3:0] ADDR_DIG2    = 4'h2;
  localparam logic [3:0] ADDR_DIG3    = 4'h3;
  localparam logic [3:0] ADDR_DIG4    = 4'h4;
  localparam logic [3:0] ADDR_DIG5    = 4'h5;
  localparam logic [3:0] ADDR_DIG6    = 4'h6;
  localparam logic [3:0] ADDR_DIG7    = 4'h7;
  localparam logic [3:0] ADDR_DIG8    = 4'h8;
  localparam logic [3:0] ADDR_DECODE  = 4'h9;
  localparam logic [3:0] ADDR_INTENS  = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM = 4'hB;
  localparam logic [3:0] ADDR_SHDN    = 4'hC;
  localparam logic [3:0] ADDR_TEST    = 4'hF;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    COMMIT    = 2'd3
  } rx_state_t;

  function automatic logic is_digit(input logic [3:0] addr);
    return (addr >= ADDR_DIG1) && (addr <= ADDR_DIG8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/max7219_rx_sync.sv
// +-------------------------------------------------------------------------+
// | max7219_rx_sync                                                         |
// | Multi-flop input synchronizer with rise/fall detection (SYNC_STAGES=2/3)|
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module max7219_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Edges come from flopped signals only, so they are glitch-free single-cycle pulses.
  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

`default_nettype wire

// File: rtl/max7219_frame_receiver.sv
// +-------------------------------------------------------------------------+
// | max7219_frame_receiver                                                  |
// | Decodes the MAX7219 DIN/NCS/CLK link into a shadow register file.       |
// | Optional: define MAX7219_FRAME_RECEIVER_VIEW_EN for RX_VIEW0..7 outputs.|
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module max7219_frame_receiver
  import max7219_frame_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic             RX_CLOCK_50,
  input  logic             RX_RESET_InLow,
  input  logic             RX_DIN,
  input  logic             RX_NCS,
  input  logic             RX_SCLK,
  output logic [7:0]       RX_ROW0,
  output logic [7:0]       RX_ROW1,
  output logic [7:0]       RX_ROW2,
  output logic [7:0]       RX_ROW3,
  output logic [7:0]       RX_ROW4,
  output logic [7:0]       RX_ROW5,
  output logic [7:0]       RX_ROW6,
  output logic [7:0]       RX_ROW7,
  output logic [7:0]       RX_DECODE,
  output logic [3:0]       RX_INTENSITY,
  output logic [2:0]       RX_SCANLIMIT,
  output logic             RX_SHUTDOWN,
  output logic             RX_TEST,
  output logic             RX_WORD_VALID,
  output logic [15:0]      RX_WORD,
  output logic             RX_FRAME_DONE,
  output logic [ERR_W-1:0] RX_ERR_CNT
`ifdef MAX7219_FRAME_RECEIVER_VIEW_EN
  ,
  output logic [7:0]       RX_VIEW0,
  output logic [7:0]       RX_VIEW1,
  output logic [7:0]       RX_VIEW2,
  output logic [7:0]       RX_VIEW3,
  output logic [7:0]       RX_VIEW4,
  output logic [7:0]       RX_VIEW5,
  output logic [7:0]       RX_VIEW6,
  output logic [7:0]       RX_VIEW7
`endif
);

  logic w_din_level;
  logic w_ncs_level, w_ncs_rise, w_ncs_fall;
  logic w_sclk_level, w_sclk_rise, w_sclk_fall;

  max7219_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk     (RX_CLOCK_50),
    .rst_n   (RX_RESET_InLow),
    .i_async (RX_DIN),
    .o_level (w_din_level),
    .o_rise  (),
    .o_fall  ()
  );

  max7219_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk     (RX_CLOCK_50),
    .rst_n   (RX_RESET_InLow),
    .i_async (RX_NCS),
    .o_level (w_ncs_level),
    .o_rise  (w_ncs_rise),
    .o_fall  (w_ncs_fall)
  );

  max7219_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk     (RX_CLOCK_50),
    .rst_n   (RX_RESET_InLow),
    .i_async (RX_SCLK),
    .o_level (w_sclk_level),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  rx_state_t              r_state;
  logic [WORD_BITS-1:0]   r_shreg;
  logic [CNT_W-1:0]       r_cnt;
  logic [7:0]             r_row [8];
  logic [7:0]             r_decode;
  logic [3:0]             r_intens;
  logic [2:0]             r_scanlim;
  logic                   r_shdn;
  logic                   r_test;
  logic                   r_word_valid;
  logic [WORD_BITS-1:0]   r_word;
  logic                   r_frame_done;
  logic [ERR_W-1:0]       r_err_cnt;

  logic [CNT_W-1:0]       w_cnt_inc;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [3:0]             w_addr;
  logic [7:0]             w_data;

  assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
  // A coincident SCLK rise counts toward the length checked at the NCS rise.
  assign w_cnt_next = w_sclk_rise ? w_cnt_inc : r_cnt;
  assign w_addr     = r_shreg[11:8];
  assign w_data     = r_shreg[7:0];

  always_ff @(posedge RX_CLOCK_50 or negedge RX_RESET_InLow) begin
    if (!RX_RESET_InLow) begin
      r_state      <= WAIT_IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      for (int k = 0; k < 8; k++) r_row[k] <= '0;
      r_decode     <= '0;
      r_intens     <= '0;
      r_scanlim    <= '0;
      r_shdn       <= 1'b1;
      r_test       <= 1'b0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
      r_frame_done <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_word_valid <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        WAIT_IDLE: begin
          if (w_ncs_level) r_state <= IDLE;
        end
        IDLE: begin
          if (w_ncs_fall) begin
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_sclk_rise) begin
            r_shreg <= {r_shreg[WORD_BITS-2:0], w_din_level};
            r_cnt   <= w_cnt_inc;
          end
          if (w_ncs_rise) begin
            if (w_cnt_next >= CNT_W'(WORD_BITS)) begin
              r_state <= COMMIT;
            end else begin
              if (r_err_cnt != {ERR_W{1'b1}}) r_err_cnt <= r_err_cnt + 1'b1;
              r_state <= IDLE;
            end
          end
        end
        COMMIT: begin
          case (w_addr)
            ADDR_NOOP:    ;
            ADDR_DECODE:  r_decode  <= w_data;
            ADDR_INTENS:  r_intens  <= w_data[3:0];
            ADDR_SCANLIM: r_scanlim <= w_data[2:0];
            ADDR_SHDN:    r_shdn    <= ~w_data[0];
            ADDR_TEST:    r_test    <= w_data[0];
            default: begin
              if (is_digit(w_addr)) r_row[3'(w_addr - 4'd1)] <= w_data;
            end
          endcase
          r_word       <= r_shreg;
          r_word_valid <= 1'b1;
          r_frame_done <= (w_addr == ADDR_DIG8);
          r_state      <= IDLE;
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

  assign RX_ROW0       = r_row[0];
  assign RX_ROW1       = r_row[1];
  assign RX_ROW2       = r_row[2];
  assign RX_ROW3       = r_row[3];
  assign RX_ROW4       = r_row[4];
  assign RX_ROW5       = r_row[5];
  assign RX_ROW6       = r_row[6];
  assign RX_ROW7       = r_row[7];
  assign RX_DECODE     = r_decode;
  assign RX_INTENSITY  = r_intens;
  assign RX_SCANLIMIT  = r_scanlim;
  assign RX_SHUTDOWN   = r_shdn;
  assign RX_TEST       = r_test;
  assign RX_WORD_VALID = r_word_valid;
  assign RX_WORD       = r_word;
  assign RX_FRAME_DONE = r_frame_done;
  assign RX_ERR_CNT    = r_err_cnt;

`ifdef MAX7219_FRAME_RECEIVER_VIEW_EN
  logic [7:0] r_view [8];

  // Display test overrides shutdown, which overrides the scan limit.
  always_ff @(posedge RX_CLOCK_50 or negedge RX_RESET_InLow) begin
    if (!RX_RESET_InLow) begin
      for (int k = 0; k < 8; k++) r_view[k] <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (r_test)                    r_view[k] <= 8'hFF;
        else if (r_shdn)               r_view[k] <= 8'h00;
        else if (3'(k) > r_scanlim)    r_view[k] <= 8'h00;
        else                           r_view[k] <= r_row[k];
      end
    end
  end

  assign RX_VIEW0 = r_view[0];
  assign RX_VIEW1 = r_view[1];
  assign RX_VIEW2 = r_view[2];
  assign RX_VIEW3 = r_view[3];
  assign RX_VIEW4 = r_view[4];
  assign RX_VIEW5 = r_view[5];
  assign RX_VIEW6 = r_view[6];
  assign RX_VIEW7 = r_view[7];
`endif

endmodule

`default_nettype wire

// File: tb/tb_max7219_frame_receiver.sv
// +-------------------------------------------------------------------------+
// | tb_max7219_frame_receiver                                               |
// | Directed self-checking bench with a word scoreboard for the receiver.   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_max7219_frame_receiver;

  logic        clk = 1'b0;
  logic        rst_n, din, ncs, sclk;
  logic [7:0]  row0, row1, row2, row3, row4, row5, row6, row7;
  logic [7:0]  decode;
  logic [3:0]  intens;
  logic [2:0]  scanlim;
  logic        shdn, test, word_valid, frame_done;
  logic [15:0] word;
  logic [7:0]  err_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  always #10 clk = ~clk;

`ifdef MAX7219_FRAME_RECEIVER_VIEW_EN
  logic [7:0] view [8];
`endif

  max7219_frame_receiver #(.SYNC_STAGES(2), .ERR_W(8)) dut (
    .RX_CLOCK_50    (clk),
    .RX_RESET_InLow (rst_n),
    .RX_DIN         (din),
    .RX_NCS         (ncs),
    .RX_SCLK        (sclk),
    .RX_ROW0        (row0),
    .RX_ROW1        (row1),
    .RX_ROW2        (row2),
    .RX_ROW3        (row3),
    .RX_ROW4        (row4),
    .RX_ROW5        (row5),
    .RX_ROW6        (row6),
    .RX_ROW7        (row7),
    .RX_DECODE      (decode),
    .RX_INTENSITY   (intens),
    .RX_SCANLIMIT   (scanlim),
    .RX_SHUTDOWN    (shdn),
    .RX_TEST        (test),
    .RX_WORD_VALID  (word_valid),
    .RX_WORD        (word),
    .RX_FRAME_DONE  (frame_done),
    .RX_ERR_CNT     (err_cnt)
`ifdef MAX7219_FRAME_RECEIVER_VIEW_EN
    ,
    .RX_VIEW0       (view[0]),
    .RX_VIEW1       (view[1]),
    .RX_VIEW2       (view[2]),
    .RX_VIEW3       (view[3]),
    .RX_VIEW4       (view[4]),
    .RX_VIEW5       (view[5]),
    .RX_VIEW6       (view[6]),
    .RX_VIEW7       (view[7])
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted word must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && word_valid) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_word observed=%h expected=none", word);
      end
      if (exp_q.size() > 0) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("word", word, e);
        check("frame_done_with_word", {15'd0, frame_done}, {15'd0, e[11:8] == 4'h8});
      end
    end
    if (rst_n && frame_done && !word_valid) begin
      checks++;
      errors++;
      $error("FAIL frame_done_alone observed=1 expected=0");
    end
  end

  task automatic ncs_low();
    ncs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // SCLK = clk/8; DIN changes while SCLK is low.
  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      din  = bits[i];
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    ncs_low();
    shift_bits(bits, n);
    ncs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic write_word(input logic [15:0] w);
    exp_q.push_back(w);
    send({16'h0, w}, 16);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ncs   = 1'b1;
    sclk  = 1'b0;
    din   = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_row0", row0, 0);
    check("rst_shutdown", shdn, 1);
    check("rst_err", err_cnt, 0);
    check("rst_word", word, 0);
    check("rst_valid", word_valid, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // First word with latency check: WORD_VALID at edge 4 after NCS rise
    exp_q.push_back(16'h0C01);
    ncs_low();
    shift_bits(32'h0C01, 16);
    check("shutdown_before_commit", shdn, 1);
    ncs = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_edge%0d", e), word_valid, {15'd0, e == 4});
    end
    repeat (6) @(negedge clk);
    check("shutdown_cleared", shdn, 0);
    check("word_0c01", word, 16'h0C01);

    // Rows
    write_word(16'h01A5);
    write_word(16'h02FF);
    write_word(16'h0311);
    write_word(16'h0422);
    write_word(16'h0533);
    write_word(16'h0644);
    write_word(16'h0755);
    write_word(16'h083C);
    check("row0", row0, 16'hA5);
    check("row1", row1, 16'hFF);
    check("row4", row4, 16'h33);
    check("row7", row7, 16'h3C);

    // Control registers, ignored addresses and don't-care top nibble
    write_word(16'h0955);
    check("decode", decode, 16'h55);
    write_word(16'h0A0F);
    check("intensity_f", intens, 16'hF);
    write_word(16'hFB05);
    check("scanlimit_5", scanlim, 5);
    write_word(16'h0F01);
    check("test_on", test, 1);
    write_word(16'h0F00);
    check("test_off", test, 0);
    write_word(16'h0D12);
    write_word(16'h0000);
    check("ignored_keeps_decode", decode, 16'h55);
    check("ignored_keeps_row0", row0, 16'hA5);
    drain();

    // Short frames
    send(32'h00000C00, 12);
    check("err_one", err_cnt, 1);
    check("short_keeps_shutdown", shdn, 0);
    check("short_keeps_row0", row0, 16'hA5);
    for (int i = 0; i < 299; i++) send(32'h00000C00, 12);
    check("err_saturated", err_cnt, 16'hFF);

    // Long frame: last 16 bits used
    exp_q.push_back(16'h0A07);
    send(32'h000F0A07, 20);
    check("long_intensity", intens, 7);
    check("long_err_unchanged", err_cnt, 16'hFF);
    drain();

    // Reset mid-frame after 9 bits of 0x0AFF
    ncs_low();
    shift_bits(32'h15, 9);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_err", err_cnt, 0);
    check("midrst_intensity", intens, 0);
    check("midrst_row7", row7, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    shift_bits(32'h7F, 7);
    ncs = 1'b1;
    repeat (10) @(negedge clk);
    write_word(16'h0B03);
    check("after_rst_scanlimit", scanlim, 3);
    check("after_rst_intensity", intens, 0);
    check("after_rst_err", err_cnt, 0);
    check("after_rst_shutdown", shdn, 1);
    check("after_rst_decode", decode, 0);
    check("after_rst_row0", row0, 0);
    drain();

`ifdef MAX7219_FRAME_RECEIVER_VIEW_EN
    for (int k = 0; k < 8; k++) write_word({4'h0, 4'(k + 1), 8'h11 * 8'(k + 1)});
    write_word(16'h0C01);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 8; k++)
      check($sformatf("view%0d_scan", k), view[k], (k <= 3) ? 16'(8'h11 * 8'(k + 1)) : 16'h0);
    write_word(16'h0F01);
    for (int k = 0; k < 8; k++) check($sformatf("view%0d_test", k), view[k], 16'hFF);
    write_word(16'h0C00);
    write_word(16'h0F00);
    for (int k = 0; k < 8; k++) check($sformatf("view%0d_off", k), view[k], 16'h00);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
